// File: rtl/conv_mac_seq_pkg.sv
// Shared types and constants for the sequential convolution MAC engine.
package conv_mac_seq_pkg;

    localparam int NBITS_DEFAULT = 20;
    localparam int NMUL_DEFAULT  = 5;
    localparam int WIN_ELEMS     = 25;
    localparam int K3_ELEMS      = 9;
    localparam int K5_ELEMS      = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } conv_states;

    typedef enum logic {
        K3 = 1'b0,
        K5 = 1'b1
    } conv_mode_e;

    typedef logic [NBITS_DEFAULT-1:0] csa_word_t;
    typedef csa_word_t [2:0]          csa_triple_t;
    typedef csa_word_t [NMUL_DEFAULT:0] csa_ops_t;

    // Number of RUN steps needed to cover a kernel with a given multiplier count.
    function automatic int steps_for(input int elems, input int nmul);
        return (elems + nmul - 1) / nmul;
    endfunction

endpackage

// File: rtl/csa_sum_n.sv
// Combinational carry-save reduction of N words followed by one carry-propagate adder.
module csa_sum_n
    import conv_mac_seq_pkg::*;
#(
    parameter int N     = NMUL_DEFAULT + 1,
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic [N-1:0][NBITS-1:0] ops,
    output logic [NBITS-1:0]        sum
);

    logic [NBITS-1:0] s_vec;
    logic [NBITS-1:0] c_vec;
    logic [NBITS-1:0] s_nxt;
    logic [NBITS-1:0] c_nxt;

    // Each 3:2 stage folds one more operand into the redundant (sum, carry) pair;
    // the carry's top bit falls off, which is exactly the modulo-2^NBITS wrap.
    always_comb begin
        s_vec = ops[0];
        c_vec = '0;
        s_nxt = '0;
        c_nxt = '0;
        for (int i = 1; i < N; i++) begin
            s_nxt = s_vec ^ c_vec ^ ops[i];
            c_nxt = ((s_vec & c_vec) | (s_vec & ops[i]) | (c_vec & ops[i])) << 1;
            s_vec = s_nxt;
            c_vec = c_nxt;
        end
        sum = s_vec + c_vec;
    end

endmodule

// File: rtl/conv_mac_seq.sv
// Time-multiplexed 3x3/5x5 dot-product engine with NMUL multiplier lanes,
// valid/ready handshakes and optional accumulation onto the previous result.
module conv_mac_seq
    import conv_mac_seq_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT,
    parameter int NMUL  = NMUL_DEFAULT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic                           in_first,
    input  logic [WIN_ELEMS-1:0][NBITS-1:0] pixels,
    input  logic [WIN_ELEMS-1:0][NBITS-1:0] weights,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NBITS-1:0]               result
);

    localparam int S3     = steps_for(K3_ELEMS, NMUL);
    localparam int S5     = steps_for(K5_ELEMS, NMUL);
    localparam int STEP_W = 5;

    conv_states                      state_q, state_d;
    conv_mode_e                      mode_q, mode_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [NBITS-1:0]                acc_q, acc_d;
    logic [NBITS-1:0]                res_q, res_d;
    logic [WIN_ELEMS-1:0][NBITS-1:0] pix_q;
    logic [WIN_ELEMS-1:0][NBITS-1:0] wgt_q;
    logic                            load;
    logic [STEP_W-1:0]               last_step;
    logic [NMUL:0][NBITS-1:0]        csa_ops;
    logic [NBITS-1:0]                csa_sum;

    // Multiplier lanes: lane j handles element step*NMUL+j; elements past the
    // kernel contribute zero so stale data in the unused window slots is ignored.
    always_comb begin
        int         k;
        int         elems;
        logic [4:0] idx;
        k          = 0;
        idx        = '0;
        elems      = (mode_q == K5) ? K5_ELEMS : K3_ELEMS;
        csa_ops[0] = acc_q;
        for (int j = 0; j < NMUL; j++) begin
            k   = int'(step_q) * NMUL + j;
            idx = 5'(k);
            if (k < elems) begin
                csa_ops[j+1] = NBITS'($signed(pix_q[idx]) * $signed(wgt_q[idx]));
            end else begin
                csa_ops[j+1] = '0;
            end
        end
    end

    csa_sum_n #(
        .N     (NMUL + 1),
        .NBITS (NBITS)
    ) u_csa (
        .ops (csa_ops),
        .sum (csa_sum)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        step_d    = step_q;
        acc_d     = acc_q;
        res_d     = res_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        last_step = (mode_q == K5) ? STEP_W'(S5 - 1) : STEP_W'(S3 - 1);
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    mode_d  = conv_mode_e'(mode);
                    step_d  = '0;
                    acc_d   = in_first ? '0 : res_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = csa_sum;
                step_d = step_q + 1'b1;
                if (step_q == last_step) begin
                    res_d   = csa_sum;
                    step_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= K3;
            step_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // Window operands are pure data: captured on accept, never reset.
    always_ff @(posedge clock) begin
        if (load) begin
            pix_q <= pixels;
            wgt_q <= weights;
        end
    end

    assign result = res_q;

endmodule
